// File: rtl/ysyx_25040111_axi_slave_mem_pkg.sv
// Shared AXI encodings, FSM state types and burst bookkeeping for the AXI slave memory.
package ysyx_25040111_axi_slave_mem_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_LEN_W  = 8;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    // Per-channel burst context latched at the address handshake.
    typedef struct packed {
        logic [AXI_LEN_W-1:0] len;
        logic [AXI_LEN_W-1:0] beat;
        logic [1:0]           burst;
        logic [1:0]           resp;
    } burst_ctx_t;

    // Only FIXED and INCR are served; everything else answers SLVERR.
    function automatic logic [1:0] burst_resp(input logic [1:0] burst);
        return ((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR)) ? AXI_RESP_OKAY
                                                                         : AXI_RESP_SLVERR;
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1 Fibonacci LFSR step.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/ysyx_25040111_sram_1r1w.sv
// Word SRAM with one synchronous read port and one byte-masked write port.
// Read data is a register: it only changes when ren is high, so it holds across stalls.
module ysyx_25040111_sram_1r1w
    import ysyx_25040111_axi_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ren,
    input  logic                  rclr,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [AXI_DATA_W-1:0] rdata,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // Read register; rclr loads zero for error beats instead of array contents.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

    // Byte-enabled write; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (wen) begin
            for (int i = 0; i < int'(AXI_STRB_W); i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_25040111_axi_slave_mem.sv
// AXI4 slave backed by a 2^MEM_Ls x 32 SRAM; independent read and write FSMs.
// Optional random wait states when AXI_SLV_DELAY_EN is defined.
module ysyx_25040111_axi_slave_mem
    import ysyx_25040111_axi_slave_mem_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int unsigned MEM_Ls = 12,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DLY_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]       awid,
    input  logic [AXI_LEN_W-1:0]  awlen,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    output logic [ID_W-1:0]       bid,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]       arid,
    input  logic [AXI_LEN_W-1:0]  arlen,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [ID_W-1:0]       rid
);

    localparam logic [32:0] MEM_LO = {1'b0, BASE};
    localparam logic [32:0] MEM_HI = MEM_LO + (33'(1) << (MEM_Ls + 2));

    function automatic logic addr_hit(input logic [AXI_ADDR_W-1:0] a);
        logic [32:0] a33;
        a33 = {1'b0, a};
        return (a33 >= MEM_LO) && (a33 < MEM_HI);
    endfunction

    function automatic logic [1:0] req_resp(input logic [AXI_ADDR_W-1:0] a, input logic [1:0] b);
        return addr_hit(a) ? burst_resp(b) : AXI_RESP_DECERR;
    endfunction

    function automatic logic [MEM_Ls-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
        return a[MEM_Ls+1:2];
    endfunction

    // INCR steps and wraps modulo the array size; FIXED holds the index.
    function automatic logic [MEM_Ls-1:0] step_idx(input logic [MEM_Ls-1:0] i, input logic [1:0] b);
        return (b == AXI_BURST_FIXED) ? i : i + MEM_Ls'(1);
    endfunction

    // SRAM port signals
    logic                  mem_ren;
    logic                  mem_rclr;
    logic [MEM_Ls-1:0]     mem_raddr;
    logic                  mem_wen;
    logic [MEM_Ls-1:0]     mem_waddr;

    // Wait-state sources (constant zero unless delays are enabled)
    logic [DLY_W-1:0]      rd_dly;
    logic [DLY_W-1:0]      wr_dly;

`ifdef AXI_SLV_DELAY_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr_q;

    // Free-running pseudo-random wait generator.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rd_dly = lfsr_q[DLY_W-1:0];
    assign wr_dly = lfsr_q[7 -: DLY_W];
`else
    assign rd_dly = '0;
    assign wr_dly = '0;
`endif

    // ---------------- read channel ----------------
    rd_state_e             rd_state_q, rd_state_d;
    burst_ctx_t            r_ctx_q, r_ctx_d;
    logic [MEM_Ls-1:0]     r_idx_q, r_idx_d;
    logic [DLY_W-1:0]      r_wait_q, r_wait_d;
    logic                  arready_d, rvalid_d, rlast_d;
    logic [1:0]            rresp_d;
    logic [ID_W-1:0]       rid_d;

    // Read FSM state and registered AR/R outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_state_q <= R_IDLE;
            r_ctx_q    <= '0;
            r_idx_q    <= '0;
            r_wait_q   <= '0;
            arready    <= 1'b1;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rresp      <= AXI_RESP_OKAY;
            rid        <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            r_ctx_q    <= r_ctx_d;
            r_idx_q    <= r_idx_d;
            r_wait_q   <= r_wait_d;
            arready    <= arready_d;
            rvalid     <= rvalid_d;
            rlast      <= rlast_d;
            rresp      <= rresp_d;
            rid        <= rid_d;
        end
    end

    // Read next-state: each beat is fetched from SRAM on the edge that raises/keeps rvalid.
    always_comb begin
        rd_state_d = rd_state_q;
        r_ctx_d    = r_ctx_q;
        r_idx_d    = r_idx_q;
        r_wait_d   = r_wait_q;
        arready_d  = arready;
        rvalid_d   = rvalid;
        rlast_d    = rlast;
        rresp_d    = rresp;
        rid_d      = rid;
        mem_ren    = 1'b0;
        mem_raddr  = r_idx_q;
        mem_rclr   = (r_ctx_q.resp != AXI_RESP_OKAY);
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_ctx_d.len   = arlen;
                    r_ctx_d.beat  = '0;
                    r_ctx_d.burst = arburst;
                    r_ctx_d.resp  = req_resp(araddr, arburst);
                    r_idx_d       = word_idx(araddr);
                    rid_d         = arid;
                    rresp_d       = r_ctx_d.resp;
                    rlast_d       = (arlen == '0);
                    arready_d     = 1'b0;
                    if (rd_dly == '0) begin
                        mem_ren    = 1'b1;
                        mem_raddr  = r_idx_d;
                        mem_rclr   = (r_ctx_d.resp != AXI_RESP_OKAY);
                        rvalid_d   = 1'b1;
                        rd_state_d = R_DATA;
                    end else begin
                        r_wait_d   = rd_dly;
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_wait_q == DLY_W'(1)) begin
                    mem_ren    = 1'b1;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    r_wait_d = r_wait_q - DLY_W'(1);
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (r_ctx_q.beat == r_ctx_q.len) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        arready_d  = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        r_ctx_d.beat = r_ctx_q.beat + 8'd1;
                        r_idx_d      = step_idx(r_idx_q, r_ctx_q.burst);
                        rlast_d      = (r_ctx_d.beat == r_ctx_q.len);
                        if (rd_dly == '0) begin
                            mem_ren   = 1'b1;
                            mem_raddr = r_idx_d;
                        end else begin
                            rvalid_d   = 1'b0;
                            r_wait_d   = rd_dly;
                            rd_state_d = R_WAIT;
                        end
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // ---------------- write channel ----------------
    wr_state_e             wr_state_q, wr_state_d;
    burst_ctx_t            w_ctx_q, w_ctx_d;
    logic [MEM_Ls-1:0]     w_idx_q, w_idx_d;
    logic [DLY_W-1:0]      w_wait_q, w_wait_d;
    logic                  w_drop_q, w_drop_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;
    logic [ID_W-1:0]       bid_d;

    // Write FSM state and registered AW/W/B outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_state_q <= W_IDLE;
            w_ctx_q    <= '0;
            w_idx_q    <= '0;
            w_wait_q   <= '0;
            w_drop_q   <= 1'b0;
            awready    <= 1'b1;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= AXI_RESP_OKAY;
            bid        <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            w_ctx_q    <= w_ctx_d;
            w_idx_q    <= w_idx_d;
            w_wait_q   <= w_wait_d;
            w_drop_q   <= w_drop_d;
            awready    <= awready_d;
            wready     <= wready_d;
            bvalid     <= bvalid_d;
            bresp      <= bresp_d;
            bid        <= bid_d;
        end
    end

    // Write next-state: beats counted against awlen; a misplaced wlast only poisons the response.
    always_comb begin
        wr_state_d = wr_state_q;
        w_ctx_d    = w_ctx_q;
        w_idx_d    = w_idx_q;
        w_wait_d   = w_wait_q;
        w_drop_d   = w_drop_q;
        awready_d  = awready;
        wready_d   = wready;
        bvalid_d   = bvalid;
        bresp_d    = bresp;
        bid_d      = bid;
        mem_wen    = 1'b0;
        mem_waddr  = w_idx_q;
        case (wr_state_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    w_ctx_d.len   = awlen;
                    w_ctx_d.beat  = '0;
                    w_ctx_d.burst = awburst;
                    w_ctx_d.resp  = req_resp(awaddr, awburst);
                    w_drop_d      = (w_ctx_d.resp != AXI_RESP_OKAY);
                    w_idx_d       = word_idx(awaddr);
                    bid_d         = awid;
                    awready_d     = 1'b0;
                    if (wr_dly == '0) begin
                        wready_d   = 1'b1;
                        wr_state_d = W_DATA;
                    end else begin
                        w_wait_d   = wr_dly;
                        wr_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_wait_q == DLY_W'(1)) begin
                    wready_d   = 1'b1;
                    wr_state_d = W_DATA;
                end else begin
                    w_wait_d = w_wait_q - DLY_W'(1);
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    mem_wen = !w_drop_q;
                    if ((wlast != (w_ctx_q.beat == w_ctx_q.len)) && (w_ctx_q.resp == AXI_RESP_OKAY)) begin
                        w_ctx_d.resp = AXI_RESP_SLVERR;
                    end
                    if (w_ctx_q.beat == w_ctx_q.len) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = w_ctx_d.resp;
                        wr_state_d = W_RESP;
                    end else begin
                        w_ctx_d.beat = w_ctx_q.beat + 8'd1;
                        w_idx_d      = step_idx(w_idx_q, w_ctx_q.burst);
                        if (wr_dly != '0) begin
                            wready_d   = 1'b0;
                            w_wait_d   = wr_dly;
                            wr_state_d = W_WAIT;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Backing store.
    ysyx_25040111_sram_1r1w #(
        .ADDR_W (MEM_Ls)
    ) u_sram (
        .clock (clock),
        .reset (reset),
        .ren   (mem_ren),
        .rclr  (mem_rclr),
        .raddr (mem_raddr),
        .rdata (rdata),
        .wen   (mem_wen),
        .waddr (mem_waddr),
        .wdata (wdata),
        .wstrb (wstrb)
    );

endmodule

// File: tb/tb_ysyx_25040111_axi_slave_mem.sv
// Scoreboard bench for the AXI slave memory: expected beats/responses are queued when a
// request is issued and popped as the DUT answers.
module tb_ysyx_25040111_axi_slave_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          ID_W = 4;
    localparam int          TO   = 64;

    typedef struct packed {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } rbeat_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } bexp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0]     awaddr, wdata, araddr, rdata;
    logic [ID_W-1:0] awid, bid, arid, rid;
    logic [7:0]      awlen, arlen;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [3:0]      wstrb;
    logic            arvalid, arready, rvalid, rready, rlast;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [4096];
    rbeat_t      r_q[$];
    bexp_t       b_q[$];

    always #5 clock = ~clock;

    ysyx_25040111_axi_slave_mem dut (
        .clock   (clock),   .reset   (reset),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awid (awid),
        .awlen   (awlen),   .awburst (awburst),
        .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wstrb (wstrb), .wlast (wlast),
        .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp),  .bid   (bid),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arid  (arid),
        .arlen   (arlen),   .arburst (arburst),
        .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rresp (rresp),
        .rlast   (rlast),   .rid     (rid)
    );

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [1:0] b);
        if (a < BASE || a >= BASE + 32'h0000_4000) return 2'b11;
        if (b == 2'b10 || b == 2'b11) return 2'b10;
        return 2'b00;
    endfunction

    task automatic ar_send(input logic [31:0] addr, input logic [ID_W-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge clock);
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
        n = 0;
        while (!arready && n < TO) begin @(negedge clock); n++; end
        if (n >= TO) begin
            checks++; errors++;
            $display("FAIL ar_handshake: arready=%0b required 1 within %0d cycles", arready, TO);
        end
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                             input int bad_last, input string tag);
        logic [1:0]  resp0;
        bexp_t       e;
        logic [11:0] idx;
        int          n;
        resp0  = exp_resp(addr, burst);
        e.resp = resp0;
        e.id   = id;
        if (resp0 == 2'b00 && bad_last >= 0 && bad_last != int'(len)) e.resp = 2'b10;
        b_q.push_back(e);
        @(negedge clock);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
        n = 0;
        while (!awready && n < TO) begin @(negedge clock); n++; end
        if (n >= TO) begin
            checks++; errors++;
            $display("FAIL %s aw_handshake: awready=%0b required 1", tag, awready);
        end
        @(negedge clock);
        awvalid = 1'b0;
        idx = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1;
            wdata  = data0 + 32'(b);
            wstrb  = strb;
            wlast  = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
            n = 0;
            while (!wready && n < TO) begin @(negedge clock); n++; end
            if (n >= TO) begin
                checks++; errors++;
                $display("FAIL %s wready_timeout beat %0d: wready=%0b required 1", tag, b, wready);
            end
            @(negedge clock);
            if (resp0 == 2'b00) begin
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
            end
            if (burst == 2'b01) idx = idx + 12'd1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < TO) begin @(negedge clock); n++; end
        e = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e.resp || bid !== e.id) begin
            errors++;
            $display("FAIL %s bresp: bvalid=%0b bresp=%0b bid=%0h required bvalid=1 bresp=%0b bid=%0h",
                     tag, bvalid, bresp, bid, e.resp, e.id);
        end
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat, input int stall_cycles,
                            input string tag);
        rbeat_t      e;
        logic [11:0] idx;
        logic [1:0]  resp;
        logic [31:0] held_d;
        logic        held_l;
        int          n;
        resp = exp_resp(addr, burst);
        idx  = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            e.data = (resp == 2'b00) ? model[idx] : 32'h0;
            e.resp = resp;
            e.last = (b == int'(len));
            e.id   = id;
            r_q.push_back(e);
            if (burst == 2'b01) idx = idx + 12'd1;
        end
        ar_send(addr, id, len, burst);
        rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < TO) begin @(negedge clock); n++; end
            if (n >= TO) begin
                checks++; errors++;
                $display("FAIL %s rvalid_timeout beat %0d: rvalid=%0b required 1", tag, b, rvalid);
                break;
            end
            if (b == stall_beat) begin
                rready = 1'b0;
                held_d = rdata;
                held_l = rlast;
                for (int c = 0; c < stall_cycles; c++) begin
                    @(negedge clock);
                    checks++;
                    if (rvalid !== 1'b1 || rdata !== held_d || rlast !== held_l) begin
                        errors++;
                        $display("FAIL %s stall_hold cycle %0d: rvalid=%0b rdata=%h rlast=%0b required 1 %h %0b",
                                 tag, c, rvalid, rdata, rlast, held_d, held_l);
                    end
                end
                rready = 1'b1;
            end
            e = r_q.pop_front();
            checks++;
            if (rdata !== e.data || rresp !== e.resp || rlast !== e.last || rid !== e.id) begin
                errors++;
                $display("FAIL %s beat %0d: rdata=%h rresp=%0b rlast=%0b rid=%0h required %h %0b %0b %0h",
                         tag, b, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
            end
            @(negedge clock);
        end
        rready = 1'b0;
        r_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready: %0b required 1", awready); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: %0b required 1", arready); end
        checks++; if (wready  !== 1'b0) begin errors++; $display("FAIL reset_wready: %0b required 0", wready); end
        checks++; if (bvalid  !== 1'b0) begin errors++; $display("FAIL reset_bvalid: %0b required 0", bvalid); end
        checks++; if (rvalid  !== 1'b0) begin errors++; $display("FAIL reset_rvalid: %0b required 0", rvalid); end
        checks++; if (rlast   !== 1'b0) begin errors++; $display("FAIL reset_rlast: %0b required 0", rlast); end
        checks++; if (bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++; $display("FAIL reset_resp: bresp=%0b rresp=%0b required 0 0", bresp, rresp);
        end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: %h required 0", rdata); end
        checks++; if (bid !== '0 || rid !== '0) begin
            errors++; $display("FAIL reset_ids: bid=%0h rid=%0h required 0 0", bid, rid);
        end
    endtask

    task automatic test_len255();
        axi_write(BASE, 4'h1, 8'd255, 2'b01, 32'h5500_0000, 4'hF, -1, "w256");
        axi_read (BASE, 4'h2, 8'd255, 2'b01, -1, 0, "r256");
    endtask

    task automatic test_incr_read();
        axi_write(BASE, 4'h4, 8'd3, 2'b01, 32'd1, 4'hF, -1, "preload");
        axi_read (BASE, 4'h5, 8'd3, 2'b01, -1, 0, "incr4");
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL incr_end: rvalid=%0b arready=%0b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_narrow_write();
        axi_write(BASE + 32'h10, 4'h6, 8'd0, 2'b01, 32'h0, 4'hF, -1, "zero");
        axi_write(BASE + 32'h10, 4'h7, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'b0011, -1, "narrow");
        checks++;
        if (model[4] !== 32'h0000_BEEF) begin
            errors++; $display("FAIL narrow_model: %h required 0000BEEF", model[4]);
        end
        axi_read(BASE + 32'h10, 4'h8, 8'd0, 2'b01, -1, 0, "narrow_rd");
    endtask

    task automatic test_decode_error();
        axi_read (32'h1000_0000, 4'h3, 8'd1, 2'b01, -1, 0, "dec_rd_low");
        axi_read (BASE - 32'd4, 4'h9, 8'd0, 2'b01, -1, 0, "dec_rd_below");
        axi_read (BASE + 32'h4000, 4'hA, 8'd0, 2'b01, -1, 0, "dec_rd_top");
        axi_write(32'h1000_0000, 4'hB, 8'd1, 2'b01, 32'h1234_0000, 4'hF, -1, "dec_wr_low");
        axi_write(BASE + 32'h4000, 4'hC, 8'd0, 2'b01, 32'h1234_0000, 4'hF, -1, "dec_wr_top");
    endtask

    task automatic test_wrap_burst();
        axi_write(BASE + 32'h20, 4'hD, 8'd1, 2'b10, 32'hBAD0_0000, 4'hF, -1, "wrap_wr");
        axi_read (BASE + 32'h20, 4'hE, 8'd1, 2'b01, -1, 0, "wrap_unchanged");
        axi_read (BASE + 32'h20, 4'hF, 8'd1, 2'b10, -1, 0, "wrap_rd");
    endtask

    task automatic test_fixed_burst();
        axi_write(BASE + 32'h30, 4'h1, 8'd2, 2'b00, 32'h0000_00A0, 4'hF, -1, "fixed_wr");
        axi_read (BASE + 32'h30, 4'h2, 8'd2, 2'b00, -1, 0, "fixed_rd");
        axi_read (BASE + 32'h34, 4'h3, 8'd0, 2'b01, -1, 0, "fixed_neighbour");
    endtask

    task automatic test_stall();
        axi_read(BASE + 32'h40, 4'h4, 8'd7, 2'b01, 3, 5, "stall");
        axi_read(BASE + 32'h60, 4'h5, 8'd2, 2'b01, 2, 3, "stall_last");
    endtask

    task automatic test_wlast_error();
        axi_write(BASE + 32'h200, 4'h6, 8'd3, 2'b01, 32'h0C00_0000, 4'hF, 1, "wlast_early");
        axi_write(BASE + 32'h210, 4'h7, 8'd2, 2'b01, 32'h0D00_0000, 4'hF, 5, "wlast_missing");
    endtask

    task automatic test_index_wrap();
        axi_write(BASE + 32'h3FFC, 4'h8, 8'd1, 2'b01, 32'h7700_0000, 4'hF, -1, "wrap_idx_wr");
        axi_read (BASE + 32'h3FFC, 4'h9, 8'd1, 2'b01, -1, 0, "wrap_idx_rd");
        axi_read (BASE, 4'hA, 8'd0, 2'b01, -1, 0, "wrap_idx_word0");
    endtask

    task automatic test_reset_mid();
        rbeat_t      e;
        logic [11:0] idx;
        int          n;
        idx = 12'd0;
        for (int b = 0; b < 4; b++) begin
            e.data = model[idx]; e.resp = 2'b00; e.last = (b == 3); e.id = 4'hB;
            r_q.push_back(e);
            idx = idx + 12'd1;
        end
        ar_send(BASE, 4'hB, 8'd3, 2'b01);
        rready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            while (!rvalid && n < TO) begin @(negedge clock); n++; end
            e = r_q.pop_front();
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || rlast !== e.last || rid !== e.id) begin
                errors++;
                $display("FAIL rst_mid beat %0d: rvalid=%0b rdata=%h rlast=%0b rid=%0h required 1 %h %0b %0h",
                         b, rvalid, rdata, rlast, rid, e.data, e.last, e.id);
            end
            @(negedge clock);
        end
        reset  = 1'b0;
        rready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        r_q.delete();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: rvalid=%0b arready=%0b rlast=%0b required 0 1 0", rvalid, arready, rlast);
        end
        axi_read(BASE + 32'h4, 4'hC, 8'd1, 2'b01, -1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        axi_read (BASE + 32'h80, 4'h1, 8'd3, 2'b01, -1, 0, "b2b_r0");
        axi_read (BASE + 32'h90, 4'h2, 8'd0, 2'b01, -1, 0, "b2b_r1");
        axi_write(BASE + 32'h90, 4'h3, 8'd1, 2'b01, 32'hC0DE_0000, 4'b1100, -1, "b2b_w");
        axi_read (BASE + 32'h90, 4'h4, 8'd1, 2'b01, -1, 0, "b2b_r2");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
        wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arburst = '0; rready = 1'b0;
        for (int i = 0; i < 4096; i++) model[i] = 32'h0;

        test_reset();
        test_len255();
        test_incr_read();
        test_narrow_write();
        test_decode_error();
        test_wrap_burst();
        test_fixed_burst();
        test_stall();
        test_wlast_error();
        test_index_wrap();
        test_reset_mid();
        test_back_to_back();

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
